// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one Avalon-style word memory port between instruction and data masters.
// Optional ARB_TIMEOUT_EN macro aborts transfers stalled for TIMEOUT_CYCLES busy cycles.
module mem_bus_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter logic [31:0] ERR_READDATA   = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] i_address,
    input  logic        i_read,
    output logic        i_waitrequest,
    output logic [31:0] i_readdata,
    input  logic [31:0] d_address,
    input  logic        d_read,
    input  logic        d_write,
    input  logic [31:0] d_writedata,
    input  logic [3:0]  d_byteenable,
    output logic        d_waitrequest,
    output logic [31:0] d_readdata,
    output logic [31:0] mem_address,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_writedata,
    output logic [3:0]  mem_byteenable,
    input  logic [31:0] mem_readdata,
    input  logic        mem_waitrequest,
    output logic        bus_error
);

    typedef enum logic [1:0] {StIdle, StBusyI, StBusyD} state_e;

    localparam logic GrantInstr = 1'b0;
    localparam logic GrantData  = 1'b1;

    state_e state, next_state;
    logic   last_grant, last_grant_next;
    logic   req_i, req_d;
    logic   timeout_hit;
    logic   xfer_end;

    assign req_i    = i_read;
    assign req_d    = d_read | d_write;
    // A transfer ends either on memory completion or on a timeout abort.
    assign xfer_end = ~mem_waitrequest | timeout_hit;

`ifdef ARB_TIMEOUT_EN
    logic [7:0] busy_cnt;

    always_ff @(posedge clk) begin
        if (reset || state == StIdle) begin
            busy_cnt <= 8'd0;
        end else if (mem_waitrequest) begin
            busy_cnt <= busy_cnt + 8'd1;
        end
    end

    assign timeout_hit = (state != StIdle) && mem_waitrequest &&
                         (busy_cnt == 8'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout_hit        = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= StIdle;
            last_grant <= GrantData;
        end else begin
            state      <= next_state;
            last_grant <= last_grant_next;
        end
    end

    always_comb begin
        next_state      = state;
        last_grant_next = last_grant;
        unique case (state)
            StIdle: begin
                if (req_i && (!req_d || last_grant == GrantData)) begin
                    next_state = StBusyI;
                end else if (req_d) begin
                    next_state = StBusyD;
                end
            end
            StBusyI: begin
                // A dropped request abandons the transfer without touching priority.
                if (!req_i) begin
                    next_state = StIdle;
                end else if (xfer_end) begin
                    next_state      = StIdle;
                    last_grant_next = GrantInstr;
                end
            end
            StBusyD: begin
                if (!req_d) begin
                    next_state = StIdle;
                end else if (xfer_end) begin
                    next_state      = StIdle;
                    last_grant_next = GrantData;
                end
            end
            default: next_state = StIdle;
        endcase
    end

    always_comb begin
        mem_address    = 32'd0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        mem_writedata  = 32'd0;
        mem_byteenable = 4'd0;
        i_waitrequest  = 1'b1;
        d_waitrequest  = 1'b1;
        i_readdata     = 32'd0;
        d_readdata     = 32'd0;
        bus_error      = 1'b0;
        if (!reset) begin
            unique case (state)
                StIdle: ;
                StBusyI: begin
                    mem_address    = i_address;
                    mem_read       = req_i;
                    mem_byteenable = 4'b1111;
                    if (req_i && xfer_end) begin
                        i_waitrequest = 1'b0;
                        i_readdata    = timeout_hit ? ERR_READDATA : mem_readdata;
                        bus_error     = timeout_hit;
                    end
                end
                StBusyD: begin
                    mem_address   = d_address;
                    mem_writedata = d_writedata;
                    if (d_write) begin
                        mem_write      = 1'b1;
                        mem_byteenable = d_byteenable;
                    end else begin
                        mem_read       = d_read;
                        mem_byteenable = 4'b1111;
                    end
                    if (req_d && xfer_end) begin
                        d_waitrequest = 1'b0;
                        d_readdata    = timeout_hit ? ERR_READDATA : mem_readdata;
                        bus_error     = timeout_hit;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios, then random traffic checked
// against a transaction-level model of the arbiter.
module tb_mem_bus_arbiter;

    localparam int unsigned TO  = 16;
    localparam logic [31:0] ERR = 32'hDEADBEEF;
`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    localparam int OwnNone = 0;
    localparam int OwnI    = 1;
    localparam int OwnD    = 2;

    logic        clk, reset;
    logic [31:0] i_address, i_readdata;
    logic        i_read, i_waitrequest;
    logic [31:0] d_address, d_writedata, d_readdata;
    logic        d_read, d_write, d_waitrequest;
    logic [3:0]  d_byteenable;
    logic [31:0] mem_address, mem_writedata, mem_readdata;
    logic        mem_read, mem_write, mem_waitrequest;
    logic [3:0]  mem_byteenable;
    logic        bus_error;

    int checks = 0;
    int errors = 0;

    // reference model state
    int  owner;
    bit  prefer_i;
    int  stall;
    bit  i_done, d_done;

    mem_bus_arbiter #(
        .TIMEOUT_CYCLES(TO),
        .ERR_READDATA  (ERR)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .i_address      (i_address),
        .i_read         (i_read),
        .i_waitrequest  (i_waitrequest),
        .i_readdata     (i_readdata),
        .d_address      (d_address),
        .d_read         (d_read),
        .d_write        (d_write),
        .d_writedata    (d_writedata),
        .d_byteenable   (d_byteenable),
        .d_waitrequest  (d_waitrequest),
        .d_readdata     (d_readdata),
        .mem_address    (mem_address),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_writedata  (mem_writedata),
        .mem_byteenable (mem_byteenable),
        .mem_readdata   (mem_readdata),
        .mem_waitrequest(mem_waitrequest),
        .bus_error      (bus_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Waits to mid-cycle, then checks {mem_read, mem_write, i_wait, d_wait, bus_error}.
    task automatic expect_ctl(input string tag, input bit rd, input bit wr, input bit iw,
                              input bit dw, input bit err);
        @(negedge clk);
        check_eq(tag, {27'd0, mem_read, mem_write, i_waitrequest, d_waitrequest, bus_error},
                 {27'd0, rd, wr, iw, dw, err});
    endtask

    task automatic idle_inputs();
        i_read          = 1'b0;
        i_address       = 32'd0;
        d_read          = 1'b0;
        d_write         = 1'b0;
        d_address       = 32'd0;
        d_writedata     = 32'd0;
        d_byteenable    = 4'd0;
        mem_readdata    = 32'd0;
        mem_waitrequest = 1'b0;
    endtask

    task automatic model_cycle();
        bit          e_rd, e_wr, e_iw, e_dw, e_err, abort;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        e_rd = 0; e_wr = 0; e_iw = 1; e_dw = 1; e_err = 0; abort = 0;
        e_addr = 32'd0; e_be = 4'd0;
        i_done = 0; d_done = 0;
        if (owner != OwnNone)
            abort = TO_EN && mem_waitrequest && (stall == int'(TO) - 1);
        if (owner == OwnI) begin
            e_addr = i_address; e_be = 4'hF; e_rd = 1'b1;
            if (!mem_waitrequest || abort) begin
                i_done = 1; e_iw = 0; e_err = abort;
            end
        end else if (owner == OwnD) begin
            e_addr = d_address;
            if (d_write) begin
                e_wr = 1'b1; e_be = d_byteenable;
            end else begin
                e_rd = 1'b1; e_be = 4'hF;
            end
            if (!mem_waitrequest || abort) begin
                d_done = 1; e_dw = 0; e_err = abort;
            end
        end
        @(negedge clk);
        check_eq("rnd_ctl", {27'd0, mem_read, mem_write, i_waitrequest, d_waitrequest, bus_error},
                 {27'd0, e_rd, e_wr, e_iw, e_dw, e_err});
        check_eq("rnd_addr", mem_address, e_addr);
        check_eq("rnd_be", {28'd0, mem_byteenable}, {28'd0, e_be});
        if (owner == OwnD && d_write) check_eq("rnd_wdata", mem_writedata, d_writedata);
        if (i_done) check_eq("rnd_irdata", i_readdata, abort ? ERR : mem_readdata);
        if (d_done) check_eq("rnd_drdata", d_readdata, abort ? ERR : mem_readdata);
        if (owner == OwnNone) begin
            stall = 0;
            if (i_read && (d_read || d_write)) owner = prefer_i ? OwnI : OwnD;
            else if (i_read) owner = OwnI;
            else if (d_read || d_write) owner = OwnD;
        end else if (i_done || d_done) begin
            prefer_i = (owner == OwnD);
            owner    = OwnNone;
        end else begin
            stall++;
        end
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        i_read = 1'b1; d_write = 1'b1; d_address = 32'h1234; d_writedata = 32'h55;
        d_byteenable = 4'hF; mem_readdata = 32'hFFFFFFFF;
        next_cycle();
        expect_ctl("rst_ctl", 0, 0, 1, 1, 0);
        check_eq("rst_addr", mem_address, 32'd0);
        check_eq("rst_wdata", mem_writedata, 32'd0);
        check_eq("rst_be", {28'd0, mem_byteenable}, 32'd0);
        check_eq("rst_irdata", i_readdata, 32'd0);
        check_eq("rst_drdata", d_readdata, 32'd0);

        // zero-wait instruction read
        next_cycle();
        idle_inputs(); reset = 1'b0;
        i_read = 1'b1; i_address = 32'hBFC00000; mem_readdata = 32'h24020005;
        expect_ctl("zw_n", 0, 0, 1, 1, 0);
        next_cycle();
        expect_ctl("zw_n1", 1, 0, 0, 1, 0);
        check_eq("zw_addr", mem_address, 32'hBFC00000);
        check_eq("zw_be", {28'd0, mem_byteenable}, 32'hF);
        check_eq("zw_rdata", i_readdata, 32'h24020005);
        next_cycle();
        i_read = 1'b0;
        expect_ctl("zw_n2", 0, 0, 1, 1, 0);

        // tie after reset: instruction first, then the re-raised fetch loses to pending data
        next_cycle(); reset = 1'b1;
        next_cycle(); reset = 1'b0;
        i_read = 1'b1; i_address = 32'h00001000; d_read = 1'b1; d_address = 32'h00002000;
        mem_readdata = 32'h11111111;
        expect_ctl("tie_n", 0, 0, 1, 1, 0);
        next_cycle();
        expect_ctl("tie_n1", 1, 0, 0, 1, 0);
        check_eq("tie_iaddr", mem_address, 32'h00001000);
        check_eq("tie_irdata", i_readdata, 32'h11111111);
        next_cycle();
        i_address = 32'h00001004;
        expect_ctl("tie_n2", 0, 0, 1, 1, 0);
        next_cycle();
        mem_readdata = 32'h22222222;
        expect_ctl("tie_n3", 1, 0, 1, 0, 0);
        check_eq("tie_daddr", mem_address, 32'h00002000);
        check_eq("tie_drdata", d_readdata, 32'h22222222);
        next_cycle();
        d_read = 1'b0;
        expect_ctl("tie_n4", 0, 0, 1, 1, 0);
        next_cycle();
        expect_ctl("tie_n5", 1, 0, 0, 1, 0);
        check_eq("tie_iaddr2", mem_address, 32'h00001004);
        next_cycle();
        i_read = 1'b0;

        // stalled write with a competing fetch
        next_cycle();
        d_write = 1'b1; d_address = 32'h80000010; d_writedata = 32'h12345678;
        d_byteenable = 4'b0011; mem_waitrequest = 1'b1;
        expect_ctl("sw_n", 0, 0, 1, 1, 0);
        for (int k = 1; k <= 3; k++) begin
            next_cycle();
            if (k == 1) begin
                i_read = 1'b1; i_address = 32'h00003000;
            end
            expect_ctl("sw_stall", 0, 1, 1, 1, 0);
            check_eq("sw_be", {28'd0, mem_byteenable}, 32'h3);
            check_eq("sw_addr", mem_address, 32'h80000010);
            check_eq("sw_wdata", mem_writedata, 32'h12345678);
        end
        next_cycle();
        mem_waitrequest = 1'b0;
        expect_ctl("sw_done", 0, 1, 1, 0, 0);
        check_eq("sw_be_done", {28'd0, mem_byteenable}, 32'h3);
        next_cycle();
        d_write = 1'b0;
        expect_ctl("sw_idle", 0, 0, 1, 1, 0);
        next_cycle();
        expect_ctl("sw_fetch", 1, 0, 0, 1, 0);
        next_cycle();
        i_read = 1'b0;

        // read+write conflict: write wins
        d_read = 1'b1; d_write = 1'b1; d_byteenable = 4'b1100;
        d_address = 32'h80000020; d_writedata = 32'hCAFEF00D;
        expect_ctl("rw_idle", 0, 0, 1, 1, 0);
        next_cycle();
        expect_ctl("rw_busy", 0, 1, 1, 0, 0);
        check_eq("rw_be", {28'd0, mem_byteenable}, 32'hC);

        // fetch so the instruction master was served last, then reset mid data stall
        next_cycle();
        d_read = 1'b0; d_write = 1'b0; i_read = 1'b1;
        expect_ctl("rb_idle0", 0, 0, 1, 1, 0);
        next_cycle();
        expect_ctl("rb_fetch", 1, 0, 0, 1, 0);
        next_cycle();
        i_read = 1'b0; d_read = 1'b1; d_address = 32'h80000030; mem_waitrequest = 1'b1;
        expect_ctl("rb_idle1", 0, 0, 1, 1, 0);
        next_cycle();
        expect_ctl("rb_busy", 1, 0, 1, 1, 0);
        next_cycle();
        reset = 1'b1; i_read = 1'b1;
        expect_ctl("rb_gated", 0, 0, 1, 1, 0);
        check_eq("rb_gated_addr", mem_address, 32'd0);
        next_cycle();
        reset = 1'b0; mem_waitrequest = 1'b0;
        expect_ctl("rb_after", 0, 0, 1, 1, 0);
        next_cycle();
        expect_ctl("rb_tie", 1, 0, 0, 1, 0);
        next_cycle();
        i_read = 1'b0;
        expect_ctl("rb_idle2", 0, 0, 1, 1, 0);
        next_cycle();
        expect_ctl("rb_data", 1, 0, 1, 0, 0);
        next_cycle();
        d_read = 1'b0;

        // stuck memory
        i_read = 1'b1; i_address = 32'h00004000; mem_waitrequest = 1'b1;
        expect_ctl("to_idle", 0, 0, 1, 1, 0);
`ifdef ARB_TIMEOUT_EN
        for (int k = 1; k <= int'(TO); k++) begin
            next_cycle();
            if (k < int'(TO)) begin
                expect_ctl("to_wait", 1, 0, 1, 1, 0);
            end else begin
                expect_ctl("to_abort", 1, 0, 0, 1, 1);
                check_eq("to_rdata", i_readdata, ERR);
            end
        end
        next_cycle();
        i_read = 1'b0;
        expect_ctl("to_after", 0, 0, 1, 1, 0);
`else
        for (int k = 0; k < 100; k++) begin
            next_cycle();
            expect_ctl("nto_wait", 1, 0, 1, 1, 0);
        end
        next_cycle();
        i_read = 1'b0;
        expect_ctl("drop_busy", 0, 0, 1, 1, 0);
        next_cycle();
        expect_ctl("drop_idle", 0, 0, 1, 1, 0);
`endif
        // abort updates priority (data next); dropped transfer does not (instruction next)
        next_cycle();
        mem_waitrequest = 1'b0; i_read = 1'b1; d_read = 1'b1;
        expect_ctl("post_idle", 0, 0, 1, 1, 0);
        next_cycle();
        if (TO_EN) expect_ctl("post_tie", 1, 0, 1, 0, 0);
        else       expect_ctl("post_tie", 1, 0, 0, 1, 0);

        // random traffic against the model
        next_cycle();
        idle_inputs(); reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        owner = OwnNone; prefer_i = 1'b1; stall = 0; i_done = 0; d_done = 0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if (!i_read || i_done) begin
                i_read    = ($urandom_range(0, 99) < 40);
                i_address = $urandom & 32'hFFFFFFFC;
            end
            if (!(d_read || d_write) || d_done) begin
                int r;
                r            = $urandom_range(0, 3);
                d_read       = (r == 1) || (r == 3);
                d_write      = (r == 2) || (r == 3);
                d_address    = $urandom & 32'hFFFFFFFC;
                d_writedata  = $urandom;
                d_byteenable = 4'($urandom);
            end
            mem_waitrequest = ($urandom_range(0, 9) < 3);
            mem_readdata    = $urandom;
            model_cycle();
            next_cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
